// File: rtl/dice_disp_pkg.sv
// dice_disp_pkg: shared state encoding, perf counter width and launch volume helper
package dice_disp_pkg;

    typedef enum logic [1:0] {IDLE, RUN, WAIT_CTA, DONE} disp_state_e;

    localparam int PERF_CNT_W = 32;

    // Extents are "minus one" encoded, so each dimension contributes ext+1
    function automatic logic [47:0] volume3(input logic [15:0] ex, input logic [15:0] ey,
                                            input logic [15:0] ez);
        logic [47:0] a, b, c;
        a = 48'(ex) + 48'd1;
        b = 48'(ey) + 48'd1;
        c = 48'(ez) + 48'd1;
        return a * b * c;
    endfunction

endpackage

// File: rtl/dice_coord3_counter.sv
// dice_coord3_counter: 3D x-fastest coordinate walker over inclusive extents,
// wrapping x into y and y into z; at_last flags the final coordinate.
module dice_coord3_counter
    import dice_disp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] ext_x,
    input  logic [W-1:0] ext_y,
    input  logic [W-1:0] ext_z,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic [W-1:0] z,
    output logic         at_last
);

    logic [W-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
    logic         x_w, y_w, z_w;

    assign x_w = x_q == ext_x;
    assign y_w = y_q == ext_y;
    assign z_w = z_q == ext_z;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
            z_d = '0;
        end else if (inc) begin
            x_d = x_w ? '0 : x_q + 1'b1;
            y_d = !x_w ? y_q : y_w ? '0 : y_q + 1'b1;
            z_d = !(x_w && y_w) ? z_q : z_w ? '0 : z_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign z       = z_q;
    assign at_last = x_w && y_w && z_w;

endmodule

// File: rtl/dice_cta_tid_dispatcher.sv
// dice_cta_tid_dispatcher: walks every thread of every CTA of a launch, one beat per accept,
// pausing between CTAs for cta_retire. Define DICE_DISP_PERF_EN for stall/wait counters.
module dice_cta_tid_dispatcher
    import dice_disp_pkg::*;
#(
    parameter int NUM_TID   = 512,
    parameter int TID_WIDTH = $clog2(NUM_TID),
    parameter int CTA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TID_WIDTH-1:0]  ntid_x,
    input  logic [TID_WIDTH-1:0]  ntid_y,
    input  logic [TID_WIDTH-1:0]  ntid_z,
    input  logic [CTA_WIDTH-1:0]  nctaid_x,
    input  logic [CTA_WIDTH-1:0]  nctaid_y,
    input  logic [CTA_WIDTH-1:0]  nctaid_z,
    input  logic                  cta_retire,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TID_WIDTH-1:0]  out_tid,
    output logic [TID_WIDTH-1:0]  out_tid_x,
    output logic [TID_WIDTH-1:0]  out_tid_y,
    output logic [TID_WIDTH-1:0]  out_tid_z,
    output logic [CTA_WIDTH-1:0]  out_ctaid_x,
    output logic [CTA_WIDTH-1:0]  out_ctaid_y,
    output logic [CTA_WIDTH-1:0]  out_ctaid_z,
    output logic                  out_last_in_cta,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] wait_cycles
);

    localparam int PW = 3 * (TID_WIDTH + 1);

    disp_state_e          state_q, state_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [TID_WIDTH-1:0] tid_q, tid_d;
    logic [TID_WIDTH-1:0] ntx_q, nty_q, ntz_q, ntx_d, nty_d, ntz_d;
    logic [CTA_WIDTH-1:0] ncx_q, ncy_q, ncz_q, ncx_d, ncy_d, ncz_d;
    logic                 latch, t_inc, c_inc, clr, t_last, c_last, too_big;
    logic [PW-1:0]        vol;

    assign vol     = PW'(volume3(16'(ntid_x), 16'(ntid_y), 16'(ntid_z)));
    assign too_big = vol > PW'(NUM_TID);

    always_comb begin
        state_d   = state_q;
        cfg_err_d = cfg_err_q;
        tid_d     = tid_q;
        latch     = 1'b0;
        t_inc     = 1'b0;
        c_inc     = 1'b0;
        clr       = 1'b0;
        if (abort) begin
            state_d   = IDLE;
            cfg_err_d = 1'b0;
            tid_d     = '0;
            clr       = 1'b1;
        end else begin
            unique case (state_q)
                IDLE, DONE: if (start) begin
                    latch     = 1'b1;
                    clr       = 1'b1;
                    tid_d     = '0;
                    cfg_err_d = too_big;
                    state_d   = too_big ? DONE : RUN;
                end
                RUN: if (out_ready) begin
                    t_inc   = 1'b1;
                    tid_d   = t_last ? '0 : tid_q + 1'b1;
                    state_d = t_last ? WAIT_CTA : RUN;
                end
                WAIT_CTA: if (cta_retire) begin
                    c_inc   = !c_last;
                    state_d = c_last ? DONE : RUN;
                end
            endcase
        end
        {ntx_d, nty_d, ntz_d} = latch ? {ntid_x, ntid_y, ntid_z} : {ntx_q, nty_q, ntz_q};
        {ncx_d, ncy_d, ncz_d} = latch ? {nctaid_x, nctaid_y, nctaid_z} : {ncx_q, ncy_q, ncz_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cfg_err_q <= 1'b0;
            tid_q     <= '0;
            {ntx_q, nty_q, ntz_q} <= '0;
            {ncx_q, ncy_q, ncz_q} <= '0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
            tid_q     <= tid_d;
            {ntx_q, nty_q, ntz_q} <= {ntx_d, nty_d, ntz_d};
            {ncx_q, ncy_q, ncz_q} <= {ncx_d, ncy_d, ncz_d};
        end
    end

    // Thread walker wraps to (0,0,0) on its final inc, so it needs no clear between CTAs
    dice_coord3_counter #(.W(TID_WIDTH)) u_tid (
        .clk(clk), .rst(rst), .clear(clr), .inc(t_inc),
        .ext_x(ntx_q), .ext_y(nty_q), .ext_z(ntz_q),
        .x(out_tid_x), .y(out_tid_y), .z(out_tid_z), .at_last(t_last)
    );

    dice_coord3_counter #(.W(CTA_WIDTH)) u_cta (
        .clk(clk), .rst(rst), .clear(clr), .inc(c_inc),
        .ext_x(ncx_q), .ext_y(ncy_q), .ext_z(ncz_q),
        .x(out_ctaid_x), .y(out_ctaid_y), .z(out_ctaid_z), .at_last(c_last)
    );

    assign out_valid       = state_q == RUN;
    assign out_last_in_cta = out_valid && t_last;
    assign out_last        = out_last_in_cta && c_last;
    assign out_tid         = tid_q;
    assign busy            = state_q == RUN || state_q == WAIT_CTA;
    assign done            = state_q == DONE;
    assign cfg_err         = cfg_err_q;

`ifdef DICE_DISP_PERF_EN
    logic [PERF_CNT_W-1:0] stall_q, stall_d, wait_q, wait_d;

    always_comb begin
        stall_d = latch ? '0 : (out_valid && !out_ready && ~&stall_q) ? stall_q + 1'b1 : stall_q;
        wait_d  = latch ? '0 : (state_q == WAIT_CTA && ~&wait_q) ? wait_q + 1'b1 : wait_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            wait_q  <= '0;
        end else begin
            stall_q <= stall_d;
            wait_q  <= wait_d;
        end
    end

    assign stall_cycles = stall_q;
    assign wait_cycles  = wait_q;
`else
    assign stall_cycles = '0;
    assign wait_cycles  = '0;
`endif

endmodule

// File: tb/tb_dice_cta_tid_dispatcher.sv
// tb_dice_cta_tid_dispatcher: randomized launches checked against a nested-loop grid model.
// Perf counter checks follow DICE_DISP_PERF_EN.
module tb_dice_cta_tid_dispatcher;
    localparam int TW = 9;
    localparam int CW = 16;

    typedef struct {
        int tid, tx, ty, tz, cx, cy, cz;
        bit lic, last;
    } beat_t;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, cta_retire = 1'b0;
    logic          out_ready = 1'b0;
    logic [TW-1:0] ntid_x = '0, ntid_y = '0, ntid_z = '0;
    logic [CW-1:0] nctaid_x = '0, nctaid_y = '0, nctaid_z = '0;
    logic          out_valid, out_last_in_cta, out_last, busy, done, cfg_err;
    logic [TW-1:0] out_tid, out_tid_x, out_tid_y, out_tid_z;
    logic [CW-1:0] out_ctaid_x, out_ctaid_y, out_ctaid_z;
    logic [31:0]   stall_cycles, wait_cycles;

    int checks = 0, errors = 0;

    dice_cta_tid_dispatcher dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ntid_x(ntid_x), .ntid_y(ntid_y), .ntid_z(ntid_z),
        .nctaid_x(nctaid_x), .nctaid_y(nctaid_y), .nctaid_z(nctaid_z),
        .cta_retire(cta_retire), .out_valid(out_valid), .out_ready(out_ready),
        .out_tid(out_tid), .out_tid_x(out_tid_x), .out_tid_y(out_tid_y), .out_tid_z(out_tid_z),
        .out_ctaid_x(out_ctaid_x), .out_ctaid_y(out_ctaid_y), .out_ctaid_z(out_ctaid_z),
        .out_last_in_cta(out_last_in_cta), .out_last(out_last), .busy(busy), .done(done),
        .cfg_err(cfg_err), .stall_cycles(stall_cycles), .wait_cycles(wait_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_perf(input string tag, input int stall, input int waitc);
`ifdef DICE_DISP_PERF_EN
        check({tag, "_stall"}, 64'(stall_cycles), 64'(stall));
        check({tag, "_wait"}, 64'(wait_cycles), 64'(waitc));
`else
        check({tag, "_stall"}, 64'(stall_cycles), 64'(0));
        check({tag, "_wait"}, 64'(wait_cycles), 64'(0));
`endif
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_cfgerr"}, 64'(cfg_err), 64'(0));
        check({tag, "_tid"}, 64'(out_tid), 64'(0));
        check({tag, "_tidxyz"}, 64'({out_tid_x, out_tid_y, out_tid_z}), 64'(0));
        check({tag, "_cta"}, 64'({out_ctaid_x, out_ctaid_y, out_ctaid_z}), 64'(0));
        check({tag, "_flags"}, 64'({out_last_in_cta, out_last}), 64'(0));
    endtask

    // Full launch: model enumerates the grid directly, then the handshake is driven randomly
    task automatic run_grid(input int bx, input int by, input int bz, input int gx, input int gy,
                            input int gz, input int pct);
        beat_t q[$];
        beat_t e;
        int    stall = 0, waitc = 0, wt_left = -1;
        bit    fin = 1'b0, retired_last = 1'b0, r;
        for (int cz = 0; cz <= gz; cz++)
            for (int cy = 0; cy <= gy; cy++)
                for (int cx = 0; cx <= gx; cx++)
                    for (int tz = 0; tz <= bz; tz++)
                        for (int ty = 0; ty <= by; ty++)
                            for (int tx = 0; tx <= bx; tx++) begin
                                e.tid  = tx + ty * (bx + 1) + tz * (bx + 1) * (by + 1);
                                e.tx = tx; e.ty = ty; e.tz = tz;
                                e.cx = cx; e.cy = cy; e.cz = cz;
                                e.lic  = tx == bx && ty == by && tz == bz;
                                e.last = e.lic && cx == gx && cy == gy && cz == gz;
                                q.push_back(e);
                            end
        @(negedge clk);
        ntid_x = TW'(bx); ntid_y = TW'(by); ntid_z = TW'(bz);
        nctaid_x = CW'(gx); nctaid_y = CW'(gy); nctaid_z = CW'(gz);
        start = 1'b1;
        for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
            @(negedge clk);
            cta_retire = 1'b0;
            // Scribble the config inputs and poke start: both must be ignored mid-launch
            start  = $urandom_range(0, 3) == 0;
            ntid_x = TW'($urandom); nctaid_x = CW'($urandom);
            if (cyc == 0) check("cfg_err_cleared", 64'(cfg_err), 64'(0));
            if (retired_last) begin
                start = 1'b0;
                check("end_done", 64'(done), 64'(1));
                check("end_busy", 64'(busy), 64'(0));
                check("end_valid", 64'(out_valid), 64'(0));
                check("end_cfgerr", 64'(cfg_err), 64'(0));
                check_perf("end", stall, waitc);
                fin = 1'b1;
            end else if (wt_left >= 0) begin
                check("wait_valid", 64'(out_valid), 64'(0));
                check("wait_busy", 64'(busy), 64'(1));
                waitc++;
                if (wt_left == 0) begin
                    cta_retire   = 1'b1;
                    retired_last = q.size() == 0;
                end
                wt_left--;
            end else begin
                r = $urandom_range(0, 99) < pct;
                out_ready = r;
                cta_retire = $urandom_range(0, 9) == 0;
                check("run_valid", 64'(out_valid), 64'(1));
                check("run_busy", 64'(busy), 64'(1));
                if (q.size() == 0) begin
                    check("model_underrun", 64'(0), 64'(1));
                    fin = 1'b1;
                end else begin
                    e = q[0];
                    check("tid", 64'(out_tid), 64'(e.tid));
                    check("tid_xyz", 64'({out_tid_x, out_tid_y, out_tid_z}),
                          64'({TW'(e.tx), TW'(e.ty), TW'(e.tz)}));
                    check("ctaid_xyz", 64'({out_ctaid_x, out_ctaid_y, out_ctaid_z}),
                          64'({CW'(e.cx), CW'(e.cy), CW'(e.cz)}));
                    check("flags", 64'({out_last_in_cta, out_last}), 64'({e.lic, e.last}));
                    if (r) begin
                        void'(q.pop_front());
                        if (e.lic) wt_left = $urandom_range(0, 3);
                    end else stall++;
                end
            end
        end
        if (!fin) check("grid_timeout", 64'(0), 64'(1));
        start = 1'b0;
        cta_retire = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset");
        check_perf("reset", 0, 0);

        run_grid(3, 1, 0, 0, 0, 0, 100);
        run_grid(1, 0, 0, 1, 1, 0, 100);
        run_grid(15, 0, 0, 0, 0, 0, 30);

        // Oversized block: rejected straight into DONE
        @(negedge clk);
        ntid_x = 9'd511; ntid_y = 9'd1; ntid_z = '0;
        nctaid_x = '0; nctaid_y = '0; nctaid_z = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cfg_done", 64'(done), 64'(1));
        check("cfg_err", 64'(cfg_err), 64'(1));
        check("cfg_valid", 64'(out_valid), 64'(0));
        check("cfg_busy", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        check("cfg_hold_valid", 64'(out_valid), 64'(0));
        check("cfg_hold_err", 64'(cfg_err), 64'(1));
        run_grid(0, 0, 0, 0, 0, 0, 100);

        // Abort at beat 5, then restart from tid 0
        @(negedge clk);
        ntid_x = 9'd15; ntid_y = '0; ntid_z = '0;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_pre_tid", 64'(out_tid), 64'(5));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_zero("abort");
        run_grid(15, 0, 0, 0, 0, 0, 60);

        for (int i = 0; i < 4; i++)
            run_grid($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 50);

        // Reset while waiting for a CTA to retire
        @(negedge clk);
        ntid_x = '0; ntid_y = '0; ntid_z = '0;
        nctaid_x = 16'd1; nctaid_y = '0; nctaid_z = '0;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("single_flags", 64'({out_valid, out_last_in_cta, out_last}), 64'(3'b110));
        @(negedge clk);
        check("rstwait_busy", 64'({busy, out_valid}), 64'(2'b10));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("rst_wait");
        check_perf("rst_wait", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
